serial_parity_framer: RTL
=========================

# serial_parity_framer

Parallel-to-serial framer that sits directly upstream of the serial parity detector and drives its serial input `x`. It accepts a WIDTH-bit word via a valid/ready handshake and shifts it out LSB-first, one bit per clock. Optionally, it appends an even-parity bit so that the downstream detector returns to its EVEN state at every frame boundary. It also supports back-to-back frames with no idle gap.

## Interface
- `WIDTH`, default 8: data bits per frame, legal range 2–32.
- `clock` input, 1 bit: rising-edge clock, the only clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `din` input, WIDTH bits: word to transmit, sampled on the handshake edge.
- `load` input, 1 bit: `din` is valid.
- `ready` output, 1 bit: framer can accept a word this cycle.
- `x` output, 1 bit: serial data to the parity detector.
- `frame` output, 1 bit: `x` carries a valid frame bit this cycle.
- `last` output, 1 bit: the current bit is the final bit of the frame.

## Operation
- State machine states: IDLE, SHIFT, PARITY (PARITY exists only with the macro defined).
- Internal registers:
  - shift register `sr[WIDTH-1:0]`
  - bit counter `cnt`, of width clog2(WIDTH)
  - parity accumulator `par`, 1 bit.
- A handshake occurs on a rising edge where `load && ready`.
- IDLE:
  - Outputs: `ready`=1, `x`=0, `frame`=0, `last`=0.
  - On handshake: `sr`←`din`, `cnt`←0, `par`←0, go to SHIFT.
- SHIFT:
  - Outputs: `x`=`sr[0]`, `frame`=1.
  - Each edge: `sr` shifts right (a 0 fills the MSB), `par`←`par`^`sr[0]`, `cnt`←`cnt`+1.
  - On the edge where `cnt`==WIDTH-1, go to PARITY (macro defined) or end the frame (macro undefined).
- PARITY:
  - Outputs: `x`=`par` (the XOR of all WIDTH data bits), `frame`=1, `last`=1.
- End of frame: the final-bit cycle is the last SHIFT cycle (macro undefined) or the PARITY cycle (macro defined).
  - `ready`=1 and `last`=1 during the final-bit cycle.
  - A handshake in the final-bit cycle reloads `sr`/`cnt`/`par` and goes to SHIFT, so the new frame's bit 0 follows with no gap.
  - With no handshake in that cycle, go to IDLE.
- `ready` is 0 in every non-final SHIFT cycle. `load` is ignored whenever `ready`=0, and `din` is not sampled.
- `x` is 0 whenever `frame`=0, so the downstream parity state does not change while the framer is idle.
- `cnt` never exceeds WIDTH-1; there is no wrap-around path.

## Timing
- Reset:
  - Asynchronous: state→IDLE, `sr`=0, `cnt`=0, `par`=0.
  - Outputs `ready`=1, `x`=0, `frame`=0, `last`=0 take effect immediately, without waiting for a clock.
- Reset mid-frame aborts the frame. No partial-frame completion occurs after reset is released.
- All outputs are decoded from registered state and contain no combinational path from `load` or `din`.
- Latency: if the handshake occurs at edge N, bit 0 appears on `x` in the cycle after edge N.
- Frame length:
  - WIDTH cycles, macro undefined.
  - WIDTH+1 cycles, macro defined.
- Throughput: one frame per WIDTH cycles (macro undefined) or WIDTH+1 cycles (macro defined) when `load` is held high continuously.
- Downstream contract (macro defined): after the PARITY bit, the detector has seen an even number of ones in the frame. Its `z` is 0 in the cycle after `last` if it was 0 at frame start.

## Configuration
- `SERIAL_PARITY_FRAMER_PARITY_EN`
  - Defined: PARITY state and `par` register are present, frames are WIDTH+1 bits, and `last` marks the parity bit.
  - Undefined: PARITY state and `par` register are absent from the netlist, frames are WIDTH bits, and `last` marks data bit WIDTH-1.

## Test plan
- Reset → `ready`=1, `x`=0, `frame`=0, `last`=0. Assert `reset` mid-frame → same values before the next edge.
- WIDTH=8, macro defined, `din`=8'hB5 with a single `load` pulse → `x` = 1,0,1,0,1,1,0,1 then parity bit 1; `frame` high for 9 cycles; `last` high only in cycle 9; downstream `z`=0 afterwards.
- Macro undefined, `din`=8'h03 → `x` = 1,1,0,0,0,0,0,0; `last` on bit 7; 8-cycle frame; downstream `z`=0.
- Macro defined, `load` held high with `din`=8'h01 then 8'hFF → the two frames are contiguous with no idle cycle; parity bits are 1 then 0; `ready` is high only in the `last` cycles.
- Macro defined, `load` pulsed during a non-final SHIFT cycle with a different `din` → pulse ignored, current frame unchanged, `ready`=0 in that cycle.
- Macro defined, `din`=8'h00 → 9 zero bits with `frame`=1; downstream `z` holds 0 throughout.

Source files
------------

// File: rtl/serial_parity_framer.sv
// Parallel-to-serial framer feeding a serial parity detector, LSB-first, valid/ready input.
// Define SERIAL_PARITY_FRAMER_PARITY_EN to append an even-parity bit to every frame.
module serial_parity_framer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             frame,
    output logic             last
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
    logic par, par_next;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] sr, sr_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             hs;
    logic             ready_next, x_next, frame_next, last_next;

    // State, datapath and output registers; outputs come straight from flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
            par   <= 1'b0;
`endif
            ready <= 1'b1;
            x     <= 1'b0;
            frame <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
            par   <= par_next;
`endif
            ready <= ready_next;
            x     <= x_next;
            frame <= frame_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
        par_next   = par;
`endif
        hs         = 1'b0;

        case (state)
            IDLE: hs = load;
            SHIFT: begin
                sr_next = {1'b0, sr[WIDTH-1:1]};
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
                par_next = par ^ sr[0];
`endif
                if (cnt == CNT_LAST) begin
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
                    state_next = PARITY;
`else
                    hs         = load;
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
            PARITY: begin
                hs         = load;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase

        // Reload in the final-bit cycle keeps frames back-to-back.
        if (hs) begin
            sr_next    = din;
            cnt_next   = '0;
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
            par_next   = 1'b0;
`endif
            state_next = SHIFT;
        end

        // Decode next-cycle outputs from the next-state values.
        ready_next = 1'b0;
        x_next     = 1'b0;
        frame_next = 1'b0;
        last_next  = 1'b0;
        case (state_next)
            IDLE: ready_next = 1'b1;
            SHIFT: begin
                frame_next = 1'b1;
                x_next     = sr_next[0];
`ifndef SERIAL_PARITY_FRAMER_PARITY_EN
                if (cnt_next == CNT_LAST) begin
                    last_next  = 1'b1;
                    ready_next = 1'b1;
                end
`endif
            end
`ifdef SERIAL_PARITY_FRAMER_PARITY_EN
            PARITY: begin
                frame_next = 1'b1;
                x_next     = par_next;
                last_next  = 1'b1;
                ready_next = 1'b1;
            end
`endif
            default: ready_next = 1'b1;
        endcase
    end

endmodule
